led_bank_ctrl: RTL
==================

LED_BANK_CTRL -- requirements
Module: led_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning the number of disable-gated LED flip-flop cells driven (legal range 2..32).
REQ-002 SHALL have parameter PERIOD_WIDTH, default 8, meaning the width of the tick-period configuration field.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, shared with the LED cell bank.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port cfg_valid_i, input, 1 bit: the configuration request is valid.
REQ-007 SHALL have port cfg_ready_o, output, 1 bit: the configuration is accepted on a cycle where cfg_valid_i and cfg_ready_o are both high.
REQ-008 SHALL have port cfg_mode_i, input, 2 bits: 00 static, 01 blink, 10 rotate, 11 bounce.
REQ-009 SHALL have port cfg_pattern_i, input, NUM_LEDS bits: the initial or base pattern.
REQ-010 SHALL have port cfg_period_i, input, PERIOD_WIDTH bits: the tick period in clocks minus one.
REQ-011 SHALL have port stop_i, input, 1 bit: clear all LEDs and return to idle.
REQ-012 SHALL have port led_dis_o, output, NUM_LEDS bits: per-cell disable, where 1 means the cell holds its value.
REQ-013 SHALL have port led_d_o, output, NUM_LEDS bits: per-cell data.
REQ-014 SHALL have port led_state_o, output, NUM_LEDS bits: shadow copy of the bank contents.
REQ-015 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement states CLEAR, IDLE, LOAD and RUN.
REQ-017 SHALL derive led_dis_o, led_d_o, led_state_o and busy_o from registers only, with no input-to-output paths to those outputs.
REQ-018 SHALL keep a shadow register, cur_q, that equals the bank contents; cur_q updates on the same edge as the bank.
REQ-019 SHALL, on a write cycle, drive led_d_o with next and led_dis_o with ~(next ^ cur_q), so that only changing bits are written, except in CLEAR.
REQ-020 SHALL, on a non-write cycle, drive led_dis_o all ones and led_d_o equal to cur_q.
REQ-021 SHALL, in CLEAR, drive led_dis_o all zeros and led_d_o all zeros, set cur_q to 0 and go to IDLE next.
REQ-022 SHALL, in IDLE, drive cfg_ready_o = ~stop_i; on acceptance, latch mode, pattern and period into mode_q, pat_q and per_q, then go to LOAD.
REQ-023 SHALL, in IDLE, treat stop_i as a no-op.
REQ-024 SHALL, in LOAD, write next = pat_q, drive cfg_ready_o = 0, set prescaler cnt to 0, set blink phase to 1 and bounce direction to left, then go to RUN.
REQ-025 SHALL, in RUN, drive cfg_ready_o = ~stop_i.
REQ-026 SHALL, in RUN, give stop_i priority: stop_i goes to CLEAR, and no configuration is accepted in the same cycle.
REQ-027 SHALL, in RUN, go to LOAD on acceptance with the new fields latched; the pending tick in that cycle is still performed.
REQ-028 SHALL, in RUN, generate a tick when cnt == per_q; on a tick cnt becomes 0 and a write occurs; otherwise cnt increments.
REQ-029 SHALL, with per_q = 0, tick every RUN cycle; the first RUN write occurs per_q+1 cycles after RUN entry.
REQ-030 SHALL, in static mode, compute next = cur_q on a tick, so led_dis_o stays all ones.
REQ-031 SHALL, in blink mode, toggle phase on a tick and compute next = phase ? pat_q : 0 using the new phase.
REQ-032 SHALL, in rotate mode, compute next as a left rotate by 1, with the MSB wrapping into bit 0.
REQ-033 SHALL, in bounce mode with direction left: if cur_q[MSB]=1, set direction right and next = cur_q>>1; else next = cur_q<<1, zero-filled.
REQ-034 SHALL, in bounce mode with direction right: if cur_q[0]=1, set direction left and next = cur_q<<1; else next = cur_q>>1.
REQ-035 SHALL keep an all-zero pattern at 0 in every mode.
REQ-036 SHALL size cnt at PERIOD_WIDTH bits; cnt never exceeds per_q, so there is no wrap beyond per_q.

Reset
REQ-037 SHALL, while rst_i is high at an edge, set the next state to CLEAR, cur_q = 0, cnt = 0, phase = 0, direction = left and mode_q/pat_q/per_q = 0.
REQ-038 SHALL, in the first cycle after reset, drive led_dis_o = 0 and led_d_o = 0 (the cells have no reset), with cfg_ready_o = 0 and busy_o = 1, followed by IDLE.
REQ-039 SHALL allow reset mid-RUN or mid-LOAD to abandon the operation and behave as REQ-037/038.

Verification (NUM_LEDS=8)
REQ-040 SHALL verify reset: rst_i high 2 cycles, then low -> one cycle with led_dis_o=00, led_d_o=00, then IDLE with led_dis_o=FF, cfg_ready_o=1, busy_o=0.
REQ-041 SHALL verify static mode: cfg mode 00, pattern A5, period 3 accepted -> LOAD cycle led_d_o=A5, led_dis_o=5A, then led_dis_o=FF for all later cycles and led_state_o=A5.
REQ-042 SHALL verify rotate: mode 10, pattern 81, period 0 -> led_state_o sequence 81, 03, 06, 0C, 18, one per cycle.
REQ-043 SHALL verify blink: mode 01, pattern 0F, period 1 -> state 0F after LOAD, 00 two cycles later, 0F two cycles after that.
REQ-044 SHALL verify bounce: mode 11, pattern 40, period 0 -> 40, 80, 40, 20, 10, 08, 04, 02, 01, 02.
REQ-045 SHALL verify stop priority: in RUN, stop_i=1 with cfg_valid_i=1 -> cfg_ready_o=0, then CLEAR (led_dis_o=00, led_d_o=00), then IDLE with led_state_o=00.

Source files
------------

// File: rtl/led_bank_ctrl.sv
// rtl/led_bank_ctrl.sv - pattern sequencer for a bank of disable-gated LED flip-flop cells
//
// Ports:
//   clk_i          clock shared with the LED cell bank
//   rst_i          synchronous active-high reset
//   cfg_valid_i    configuration request valid
//   cfg_ready_o    configuration accepted when valid and ready are both high
//   cfg_mode_i     00 static, 01 blink, 10 rotate, 11 bounce
//   cfg_pattern_i  initial / base pattern
//   cfg_period_i   tick period in clocks minus one
//   stop_i         clear all LEDs and return to idle
//   led_dis_o      per-cell disable (1 = cell holds its value)
//   led_d_o        per-cell data
//   led_state_o    shadow copy of the bank contents
//   busy_o         high whenever the controller is not idle
module led_bank_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [1:0]              cfg_mode_i,
  input  logic [NUM_LEDS-1:0]     cfg_pattern_i,
  input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
  input  logic                    stop_i,
  output logic [NUM_LEDS-1:0]     led_dis_o,
  output logic [NUM_LEDS-1:0]     led_d_o,
  output logic [NUM_LEDS-1:0]     led_state_o,
  output logic                    busy_o
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [1:0]              state_q, state_d;
  logic [NUM_LEDS-1:0]     cur_q, cur_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic                    dir_q, dir_d;
  logic [1:0]              mode_q, mode_d;
  logic [NUM_LEDS-1:0]     pat_q, pat_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d;

  logic                    wr;
  logic [NUM_LEDS-1:0]     nxt;
  logic                    tick;
  logic [NUM_LEDS-1:0]     run_next;
  logic                    run_phase;
  logic                    run_dir;

  // Next pattern for a RUN tick; depends only on registered state so the
  // cell-facing outputs never see an input combinationally.
  always_comb begin
    run_next  = cur_q;
    run_phase = phase_q;
    run_dir   = dir_q;
    unique case (mode_q)
      MODE_STATIC: run_next = cur_q;
      MODE_BLINK: begin
        run_phase = ~phase_q;
        run_next  = run_phase ? pat_q : '0;
      end
      MODE_ROTATE: run_next = {cur_q[NUM_LEDS-2:0], cur_q[NUM_LEDS-1]};
      default: begin
        if (dir_q == DIR_LEFT) begin
          if (cur_q[NUM_LEDS-1]) begin
            run_dir  = DIR_RIGHT;
            run_next = cur_q >> 1;
          end else begin
            run_next = cur_q << 1;
          end
        end else begin
          if (cur_q[0]) begin
            run_dir  = DIR_LEFT;
            run_next = cur_q << 1;
          end else begin
            run_next = cur_q >> 1;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    pat_d       = pat_q;
    per_d       = per_q;
    cfg_ready_o = 1'b0;
    wr          = 1'b0;
    nxt         = cur_q;
    tick        = (cnt_q == per_q);

    unique case (state_q)
      ST_CLEAR: begin
        cur_d   = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cfg_ready_o = ~stop_i;
        if (cfg_valid_i && !stop_i) begin
          mode_d  = cfg_mode_i;
          pat_d   = cfg_pattern_i;
          per_d   = cfg_period_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr      = 1'b1;
        nxt     = pat_q;
        cur_d   = pat_q;
        cnt_d   = '0;
        phase_d = 1'b1;
        dir_d   = DIR_LEFT;
        state_d = ST_RUN;
      end
      default: begin
        cfg_ready_o = ~stop_i;
        // The tick is taken even when stop or a new config arrives this cycle.
        if (tick) begin
          cnt_d   = '0;
          wr      = 1'b1;
          nxt     = run_next;
          cur_d   = run_next;
          phase_d = run_phase;
          dir_d   = run_dir;
        end else begin
          cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end
        if (stop_i) begin
          state_d = ST_CLEAR;
        end else if (cfg_valid_i) begin
          mode_d  = cfg_mode_i;
          pat_d   = cfg_pattern_i;
          per_d   = cfg_period_i;
          state_d = ST_LOAD;
        end
      end
    endcase
  end

  // Only bits that change are written; CLEAR forces every cell to zero
  // because the cells themselves have no reset.
  always_comb begin
    if (state_q == ST_CLEAR) begin
      led_dis_o = '0;
      led_d_o   = '0;
    end else if (wr) begin
      led_dis_o = ~(nxt ^ cur_q);
      led_d_o   = nxt;
    end else begin
      led_dis_o = '1;
      led_d_o   = cur_q;
    end
  end

  assign led_state_o = cur_q;
  assign busy_o      = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cur_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      dir_q   <= DIR_LEFT;
      mode_q  <= '0;
      pat_q   <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      per_q   <= per_d;
    end
  end

endmodule
